// File: rtl/spec_fifo_arb.sv
// Round-robin packet arbiter feeding a speculative FIFO: forwards one requester's
// beats at a time, commits on the last beat, reverts on abort or stall timeout.
module spec_fifo_arb #(
  parameter int WIDTH     = 32,
  parameter int NREQ      = 4,
  parameter int MAX_STALL = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  input  logic [NREQ-1:0]           req_last,
  input  logic [NREQ-1:0]           req_abort,
  output logic [NREQ-1:0]           req_ready,
  output logic                      fifo_valid,
  output logic [WIDTH-1:0]          fifo_data,
  input  logic                      fifo_ready,
  output logic                      fifo_commit,
  output logic                      fifo_revert,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      drop_pulse,
  output logic                      drop_reason
);

  localparam int GW = $clog2(NREQ);
  localparam int SW = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   rr_ptr, pick_id, next_ptr, idx;
  logic            pick_found;
  logic [SW-1:0]   stall_cnt;
  logic            stall_max, stall_clr, stall_inc;
  logic            grant_load, end_pkt, drop_set, drop_why;

  // First requesting index at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = GW'((int'(rr_ptr) + k) % NREQ);
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx;
      end
    end
  end

  assign next_ptr  = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + GW'(1);
  assign fifo_data = req_data[grant_id*WIDTH +: WIDTH];
  assign busy      = (state != IDLE);
  assign stall_max = (stall_cnt == SW'(MAX_STALL));

  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    fifo_valid  = 1'b0;
    fifo_commit = 1'b0;
    fifo_revert = 1'b0;
    grant_load  = 1'b0;
    end_pkt     = 1'b0;
    drop_set    = 1'b0;
    drop_why    = 1'b0;
    stall_clr   = 1'b0;
    stall_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_load = 1'b1;
          stall_clr  = 1'b1;
          state_nxt  = XFER;
        end
      end
      XFER: begin
        if (req_abort[grant_id]) begin
          fifo_revert = 1'b1;
          drop_set    = 1'b1;
          end_pkt     = 1'b1;
          state_nxt   = IDLE;
        end else if (stall_max) begin
          fifo_revert = 1'b1;
          drop_set    = 1'b1;
          drop_why    = 1'b1;
          state_nxt   = FLUSH;
        end else begin
          fifo_valid          = req_valid[grant_id];
          req_ready[grant_id] = fifo_ready;
          if (req_valid[grant_id] && fifo_ready) begin
            stall_clr = 1'b1;
            if (req_last[grant_id]) begin
              fifo_commit = 1'b1;
              end_pkt     = 1'b1;
              state_nxt   = IDLE;
            end
          end else if (!fifo_ready) begin
            stall_inc = 1'b1;
          end
        end
      end
      FLUSH: begin
        // Swallow the rest of a timed-out packet so the requester can move on
        req_ready[grant_id] = 1'b1;
        if ((req_valid[grant_id] && req_last[grant_id]) || req_abort[grant_id]) begin
          end_pkt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant_id    <= '0;
      rr_ptr      <= '0;
      stall_cnt   <= '0;
      drop_pulse  <= 1'b0;
      drop_reason <= 1'b0;
    end else begin
      state      <= state_nxt;
      drop_pulse <= drop_set;
      if (grant_load) grant_id <= pick_id;
      if (end_pkt) rr_ptr <= next_ptr;
      if (drop_set) drop_reason <= drop_why;
      if (stall_clr) stall_cnt <= '0;
      else if (stall_inc) stall_cnt <= stall_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_spec_fifo_arb.sv
// Directed bench for spec_fifo_arb: fairness, wrap-around, abort, timeout,
// backpressure and asynchronous reset, with hand-computed expectations.
module tb_spec_fifo_arb;

  localparam int WIDTH     = 8;
  localparam int NREQ      = 4;
  localparam int MAX_STALL = 4;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_abort;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_valid;
  logic [WIDTH-1:0]      fifo_data;
  logic                  fifo_ready;
  logic                  fifo_commit;
  logic                  fifo_revert;
  logic [1:0]            grant_id;
  logic                  busy;
  logic                  drop_pulse;
  logic                  drop_reason;

  int compareCount = 0;
  int errCount     = 0;

  spec_fifo_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_abort(req_abort), .req_ready(req_ready),
    .fifo_valid(fifo_valid), .fifo_data(fifo_data), .fifo_ready(fifo_ready),
    .fifo_commit(fifo_commit), .fifo_revert(fifo_revert),
    .grant_id(grant_id), .busy(busy),
    .drop_pulse(drop_pulse), .drop_reason(drop_reason)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l,
                               input logic [3:0] a, input logic r);
    req_valid  = v;
    req_last   = l;
    req_abort  = a;
    fifo_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    int g;
    int beat;
    logic rdy;
    logic [3:0] lastMask;

    reset = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0; req_abort = '0; fifo_ready = 1'b0;
    #2;
    checkOutput("rst_req_ready", 32'(req_ready), 0);
    checkOutput("rst_fifo_valid", 32'(fifo_valid), 0);
    checkOutput("rst_commit", 32'(fifo_commit), 0);
    checkOutput("rst_revert", 32'(fifo_revert), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_drop_pulse", 32'(drop_pulse), 0);
    checkOutput("rst_drop_reason", 32'(drop_reason), 0);
    checkOutput("rst_grant_id", 32'(grant_id), 0);
    tick();
    reset = 1'b0;

    // Fairness: requesters 0 and 2 always have 3-beat packets pending
    for (int p = 0; p < 4; p++) begin
      g = (p % 2 == 0) ? 0 : 2;
      applyStimulus(4'b0101, 4'b0000, 4'b0000, 1'b1);
      checkOutput("fair_bubble_busy", 32'(busy), 0);
      checkOutput("fair_bubble_ready", 32'(req_ready), 0);
      checkOutput("fair_bubble_commit", 32'(fifo_commit), 0);
      tick();
      checkOutput("fair_grant", 32'(grant_id), 32'(g));
      for (int b = 1; b <= 3; b++) begin
        req_data[g*WIDTH +: WIDTH] = 8'(g * 16 + p * 4 + b);
        lastMask = (b == 3) ? 4'(1 << g) : 4'b0000;
        applyStimulus(4'b0101, lastMask, 4'b0000, 1'b1);
        checkOutput("fair_valid", 32'(fifo_valid), 1);
        checkOutput("fair_data", 32'(fifo_data), 32'(g * 16 + p * 4 + b));
        checkOutput("fair_ready", 32'(req_ready), 32'(1 << g));
        checkOutput("fair_commit", 32'(fifo_commit), (b == 3) ? 1 : 0);
        tick();
      end
    end

    // Wrap-around: pointer now at 3, requesters 0 and 3 pending
    applyStimulus(4'b1001, 4'b0000, 4'b0000, 1'b1);
    checkOutput("wrap_bubble_busy", 32'(busy), 0);
    tick();
    checkOutput("wrap_grant_first", 32'(grant_id), 3);
    req_data[3*WIDTH +: WIDTH] = 8'h3A;
    applyStimulus(4'b1001, 4'b1000, 4'b0000, 1'b1);
    checkOutput("wrap_ready3", 32'(req_ready), 32'h8);
    checkOutput("wrap_data3", 32'(fifo_data), 32'h3A);
    checkOutput("wrap_commit3", 32'(fifo_commit), 1);
    tick();
    applyStimulus(4'b1001, 4'b0000, 4'b0000, 1'b1);
    checkOutput("wrap_bubble2_commit", 32'(fifo_commit), 0);
    tick();
    checkOutput("wrap_grant_second", 32'(grant_id), 0);
    req_data[0 +: WIDTH] = 8'h0B;
    applyStimulus(4'b1001, 4'b0001, 4'b0000, 1'b1);
    checkOutput("wrap_commit0", 32'(fifo_commit), 1);
    tick();

    // Abort: requester 1 sends two beats then abandons the packet
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b1);
    tick();
    checkOutput("abort_grant", 32'(grant_id), 1);
    req_data[1*WIDTH +: WIDTH] = 8'hA1;
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b1);
    checkOutput("abort_beat1_data", 32'(fifo_data), 32'hA1);
    checkOutput("abort_beat1_ready", 32'(req_ready), 32'h2);
    tick();
    req_data[1*WIDTH +: WIDTH] = 8'hA2;
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b1);
    checkOutput("abort_beat2_data", 32'(fifo_data), 32'hA2);
    tick();
    applyStimulus(4'b0000, 4'b0000, 4'b0010, 1'b1);
    checkOutput("abort_revert", 32'(fifo_revert), 1);
    checkOutput("abort_no_commit", 32'(fifo_commit), 0);
    checkOutput("abort_fifo_valid", 32'(fifo_valid), 0);
    checkOutput("abort_ready", 32'(req_ready), 0);
    checkOutput("abort_drop_early", 32'(drop_pulse), 0);
    tick();
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
    checkOutput("abort_drop_pulse", 32'(drop_pulse), 1);
    checkOutput("abort_drop_reason", 32'(drop_reason), 0);
    checkOutput("abort_idle", 32'(busy), 0);
    checkOutput("abort_revert_once", 32'(fifo_revert), 0);
    tick();
    checkOutput("abort_drop_single", 32'(drop_pulse), 0);

    // Timeout: requester 3, 5-beat packet, FIFO stalls after beat 1
    applyStimulus(4'b1000, 4'b0000, 4'b0000, 1'b1);
    tick();
    checkOutput("to_grant", 32'(grant_id), 3);
    req_data[3*WIDTH +: WIDTH] = 8'h31;
    applyStimulus(4'b1000, 4'b0000, 4'b0000, 1'b1);
    checkOutput("to_beat1_ready", 32'(req_ready), 32'h8);
    tick();
    req_data[3*WIDTH +: WIDTH] = 8'h32;
    for (int s = 1; s <= 4; s++) begin
      applyStimulus(4'b1000, 4'b0000, 4'b0000, 1'b0);
      checkOutput("to_stall_valid", 32'(fifo_valid), 1);
      checkOutput("to_stall_ready", 32'(req_ready), 0);
      checkOutput("to_stall_no_revert", 32'(fifo_revert), 0);
      tick();
    end
    applyStimulus(4'b1000, 4'b0000, 4'b0000, 1'b0);
    checkOutput("to_revert", 32'(fifo_revert), 1);
    checkOutput("to_revert_valid", 32'(fifo_valid), 0);
    checkOutput("to_revert_ready", 32'(req_ready), 0);
    checkOutput("to_revert_commit", 32'(fifo_commit), 0);
    tick();
    for (int b = 2; b <= 5; b++) begin
      req_data[3*WIDTH +: WIDTH] = 8'(8'h30 + b);
      lastMask = (b == 5) ? 4'b1000 : 4'b0000;
      applyStimulus(4'b1000, lastMask, 4'b0000, 1'b0);
      if (b == 2) begin
        checkOutput("to_drop_pulse", 32'(drop_pulse), 1);
        checkOutput("to_drop_reason", 32'(drop_reason), 1);
      end
      checkOutput("to_flush_ready", 32'(req_ready), 32'h8);
      checkOutput("to_flush_valid", 32'(fifo_valid), 0);
      checkOutput("to_flush_revert", 32'(fifo_revert), 0);
      checkOutput("to_flush_busy", 32'(busy), 1);
      tick();
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
    checkOutput("to_idle", 32'(busy), 0);

    // Backpressure: fifo_ready toggles every cycle over an 8-beat packet
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b1);
    tick();
    checkOutput("bp_grant", 32'(grant_id), 1);
    for (int c = 0; c < 16; c++) begin
      beat = c / 2 + 1;
      rdy = (c % 2 == 1);
      req_data[1*WIDTH +: WIDTH] = 8'(8'hB0 + beat);
      lastMask = (beat == 8) ? 4'b0010 : 4'b0000;
      applyStimulus(4'b0010, lastMask, 4'b0000, rdy);
      checkOutput("bp_no_revert", 32'(fifo_revert), 0);
      if (rdy) begin
        checkOutput("bp_ready", 32'(req_ready), 32'h2);
        checkOutput("bp_data", 32'(fifo_data), 32'(8'hB0 + beat));
        checkOutput("bp_commit", 32'(fifo_commit), (beat == 8) ? 1 : 0);
      end else begin
        checkOutput("bp_stall_ready", 32'(req_ready), 0);
        checkOutput("bp_stall_commit", 32'(fifo_commit), 0);
      end
      tick();
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
    checkOutput("bp_idle", 32'(busy), 0);

    // Asynchronous reset in the middle of a packet from requester 2
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b1);
    tick();
    checkOutput("rst_mid_grant", 32'(grant_id), 2);
    req_data[2*WIDTH +: WIDTH] = 8'hC1;
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b1);
    checkOutput("rst_mid_valid", 32'(fifo_valid), 1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("arst_req_ready", 32'(req_ready), 0);
    checkOutput("arst_fifo_valid", 32'(fifo_valid), 0);
    checkOutput("arst_commit", 32'(fifo_commit), 0);
    checkOutput("arst_revert", 32'(fifo_revert), 0);
    checkOutput("arst_busy", 32'(busy), 0);
    checkOutput("arst_drop_pulse", 32'(drop_pulse), 0);
    checkOutput("arst_grant_id", 32'(grant_id), 0);
    tick();
    reset = 1'b0;
    applyStimulus(4'b0101, 4'b0000, 4'b0000, 1'b1);
    checkOutput("post_rst_busy", 32'(busy), 0);
    tick();
    checkOutput("post_rst_grant", 32'(grant_id), 0);
    applyStimulus(4'b0101, 4'b0000, 4'b0000, 1'b1);
    checkOutput("post_rst_ready", 32'(req_ready), 32'h1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errCount);
    $finish;
  end

endmodule

// File: doc/spec_fifo_arb.md
# spec_fifo_arb

Round-robin packet arbiter and commit/revert sequencer for the write side of the speculative FIFO. Up to NREQ requesters each present packets as beat streams. The block grants one requester at a time and forwards its beats into the FIFO. It pulses commit on the last beat and pulses revert on requester abort or on a stall timeout, so the FIFO reader only ever sees whole packets. It sits between packet producers and the FIFO's valid_in/ready_in/commit/revert ports.

## Interface
- WIDTH, 32, data beat width
- NREQ, 4, number of requesters (2..16)
- MAX_STALL, 255, consecutive XFER cycles with fifo_ready low before the packet is dropped (>=1)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  beat valid, one bit per requester
- req_data  in  NREQ*WIDTH  beat data; requester i occupies bits [i*WIDTH +: WIDTH]
- req_last  in  NREQ  beat is the final beat of its packet
- req_abort  in  NREQ  requester abandons its current packet (level, sampled only while granted)
- req_ready  out  NREQ  beat accepted from requester i
- fifo_valid  out  1  to FIFO valid_in
- fifo_data  out  WIDTH  to FIFO data_in
- fifo_ready  in  1  from FIFO ready_in
- fifo_commit  out  1  to FIFO commit
- fifo_revert  out  1  to FIFO revert
- grant_id  out  $clog2(NREQ)  current or last granted requester
- busy  out  1  state != IDLE
- drop_pulse  out  1  one-cycle pulse when a packet is reverted
- drop_reason  out  1  0 = abort, 1 = timeout; valid with drop_pulse

## Operation
- States: IDLE, XFER, FLUSH. Registers: state, grant_id, rr_ptr, stall_cnt (width $clog2(MAX_STALL+1)), drop_pulse, drop_reason.
- IDLE: if any req_valid bit is set, select the first set bit searching from rr_ptr upward (mod NREQ). Register it into grant_id, clear stall_cnt, go to XFER. No beat is forwarded in IDLE. All req_ready bits are 0.
- XFER, with g = grant_id. Evaluate in priority order:
  - req_abort[g]=1: fifo_valid=0, req_ready=0, fifo_revert=1, drop_pulse=1 next cycle with drop_reason=0, go to IDLE, rr_ptr <= g+1.
  - else stall_cnt==MAX_STALL: fifo_valid=0, req_ready=0, fifo_revert=1, drop_pulse=1 next cycle with drop_reason=1, go to FLUSH.
  - else normal: fifo_valid=req_valid[g], fifo_data=req_data[g], req_ready[g]=fifo_ready.
    - Beat transfers when req_valid[g] & fifo_ready. stall_cnt is cleared on a transfer and incremented when fifo_ready=0; it holds when the requester is idle with fifo_ready=1.
    - A transfer with req_last[g]=1 asserts fifo_commit in the same cycle, goes to IDLE, and sets rr_ptr <= g+1.
- FLUSH: req_ready[g]=1, fifo_valid=0. Discard beats until req_valid[g]&req_last[g], or until req_abort[g]; then go to IDLE with rr_ptr <= g+1.
- fifo_commit and fifo_revert are never asserted in the same cycle. Neither is asserted outside XFER.
- req_ready bits other than g are always 0. Ungranted requesters wait.
- fifo_data equals req_data slice grant_id in every state; it is meaningful only when fifo_valid=1.

## Timing
- Reset (async assert, removal synchronous to clk) gives: state=IDLE, grant_id=0, rr_ptr=0, stall_cnt=0. All outputs are 0: req_ready, fifo_valid, fifo_commit, fifo_revert, busy, drop_pulse, drop_reason, grant_id.
- Reset mid-packet drops the in-flight packet with no revert pulse. The system resets the FIFO together with this block.
- Grant latency: first beat can be forwarded 1 cycle after req_valid is seen in IDLE.
- Between packets there is exactly one IDLE bubble cycle. Peak throughput is L/(L+1) for L-beat packets.
- Commit is combinational with the last beat. Revert is combinational with abort/timeout detection.
- drop_pulse is registered: it is high for exactly one cycle, the cycle after fifo_revert.
- Fairness: after any packet end (commit, abort, or flush end) the granted requester gets lowest priority.
- A packet larger than the FIFO free space can never complete. The stall timeout guarantees forward progress: MAX_STALL stalled cycles, then revert and FLUSH.

## Test plan
- Fairness: NREQ=4, WIDTH=8. Requesters 0 and 2 each hold 3-beat packets continuously. Required: grants alternate 0,2,0,2. Each packet produces exactly one fifo_commit, coincident with its beat 3. There is one bubble cycle between packets.
- Abort: requester 1 sends 2 beats (0xA1, 0xA2), then asserts req_abort. Required: fifo_revert=1 for one cycle with no commit. drop_pulse next cycle with drop_reason=0. FIFO output stays empty.
- Timeout: MAX_STALL=4. Hold fifo_ready=0 after the first beat of a 5-beat packet from requester 3. Required: fifo_revert on the 5th stalled cycle, then drop_reason=1. The remaining 4 beats are accepted with fifo_valid=0. State reaches IDLE after the req_last beat.
- Wrap-around: rr_ptr=3 with requesters 0 and 3 both requesting. Required: 3 is granted first, then 0.
- Backpressure: toggle fifo_ready every cycle during an 8-beat packet. Required: 8 transfers in order, no timeout, commit on beat 8 only.
- Async reset asserted mid-XFER. Required: all outputs go to 0 immediately, without waiting for a clock edge. The next grant restarts the search from requester 0.
